// File: rtl/fft_sink_pkg.sv
// fft_sink_pkg: shared FSM type, datapath widths and abs helper for the FFT frame sink
package fft_sink_pkg;
   typedef enum logic {IDLE, CAPTURE} state_e;
   localparam int MAG_W = 25;
   localparam int DATA_W = 24;
   function automatic logic [DATA_W-2:0] sat_abs(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] m;
      m = x[DATA_W-1] ? -x : x;
      return m[DATA_W-1] ? '1 : m[DATA_W-2:0];
   endfunction
endpackage

// File: rtl/fft_mag_approx.sv
// fft_mag_approx: 3-stage alpha-max-beta-min magnitude pipe with tag sideband
module fft_mag_approx
   import fft_sink_pkg::*;
#(
   parameter int OUT_SHIFT = 8,
   parameter int OUT_W = 16,
   parameter int TAG_W = 20
) (
   input logic clk,
   input logic rst,
   input logic v_i,
   input logic signed [DATA_W-1:0] re_i,
   input logic signed [DATA_W-1:0] im_i,
   input logic [TAG_W-1:0] tag_i,
   output logic v_o,
   output logic [OUT_W-1:0] mag_o,
   output logic [TAG_W-1:0] tag_o
);
   logic [DATA_W-2:0] a_q, b_q, mx_q, mn_q;
   logic [TAG_W-1:0] t1_q, t2_q;
   logic v1_q, v2_q;
   logic [MAG_W-1:0] sum, sh;
   // sum of max + min/4 + min/8, then scaled down before saturation
   always_comb begin
      sum = MAG_W'(mx_q) + MAG_W'(mn_q >> 2) + MAG_W'(mn_q >> 3);
      sh = sum >> OUT_SHIFT;
   end
   // only the valid bits are flushed by reset; data follows them unqualified
   always_ff @(posedge clk) begin
      if (rst) {v1_q, v2_q, v_o} <= '0;
      else {v1_q, v2_q, v_o} <= {v_i, v1_q, v2_q};
   end
   // abs -> max/min -> saturated magnitude, tag travelling in lockstep
   always_ff @(posedge clk) begin
      a_q <= sat_abs(re_i);
      b_q <= sat_abs(im_i);
      t1_q <= tag_i;
      mx_q <= (a_q > b_q) ? a_q : b_q;
      mn_q <= (a_q > b_q) ? b_q : a_q;
      t2_q <= t1_q;
      mag_o <= (sh > MAG_W'((1 << OUT_W) - 1)) ? '1 : sh[OUT_W-1:0];
      tag_o <= t2_q;
   end
endmodule

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: checks FFT output framing and stores bin magnitudes in a ping-pong buffer
module fft_frame_sink
   import fft_sink_pkg::*;
#(
   parameter int N_POINTS = 4096,
   parameter int ADDR_W = 12,
   parameter int OUT_SHIFT = 8,
   parameter int OUT_W = 16
) (
   input logic MCLK,
   input logic reset,
   input logic source_valid,
   input logic source_sop,
   input logic source_eop,
   input logic signed [DATA_W-1:0] source_real,
   input logic signed [DATA_W-1:0] source_imag,
   input logic signed [5:0] source_exp,
   input logic [1:0] source_error,
   output logic source_ready,
   input logic [ADDR_W-1:0] rd_addr,
   output logic [OUT_W-1:0] rd_data,
   output logic frame_done,
   output logic [5:0] frame_exp,
   output logic [7:0] frame_count,
   output logic frame_err
);
   localparam int TAG_W = ADDR_W + 8;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
   state_e state_q;
   logic [ADDR_W-1:0] idx_q, wr_idx, p_idx;
   logic [5:0] exp_q, p_exp, fexp_q;
   logic [7:0] count_q;
   logic nb_q, wr_bank_q, ready_q, err_q;
   logic acc, bad, start, in_cap, at_end, wr_v, wr_last, err;
   logic p_v, p_last, p_bank;
   logic [TAG_W-1:0] p_tag;
   logic [OUT_W-1:0] p_mag, rd_q;
   logic [OUT_W-1:0] ram [2*N_POINTS];
   assign source_ready = ready_q;
   assign frame_err = err_q;
   assign frame_done = p_v & p_last;
   assign frame_count = count_q;
   assign frame_exp = fexp_q;
   assign rd_data = rd_q;
   assign {p_exp, p_last, p_bank, p_idx} = p_tag;
   // classify the accepted beat: written, committing, or breaking the frame
   always_comb begin
      acc = source_valid & ready_q;
      bad = source_error != '0;
      in_cap = state_q == CAPTURE;
      at_end = idx_q == LAST_IDX;
      start = acc & source_sop & ~bad;
      wr_v = start | (acc & in_cap & ~bad);
      wr_idx = source_sop ? '0 : idx_q;
      wr_last = acc & in_cap & ~bad & ~source_sop & source_eop & at_end;
      err = acc & in_cap & (bad | source_sop | (source_eop ^ at_end));
   end
   // frame FSM; nb_q flips at eop accept so a following sop already targets the next bank
   always_ff @(posedge MCLK) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q <= '0;
         exp_q <= '0;
         nb_q <= 1'b0;
         ready_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         err_q <= err;
         if (start) begin
            state_q <= CAPTURE;
            idx_q <= ADDR_W'(1);
            exp_q <= source_exp;
         end else if (err) begin
            state_q <= IDLE;
         end else if (wr_last) begin
            state_q <= IDLE;
            nb_q <= ~nb_q;
         end else if (acc & in_cap) begin
            idx_q <= idx_q + ADDR_W'(1);
         end
      end
   end
   fft_mag_approx #(
      .OUT_SHIFT(OUT_SHIFT),
      .OUT_W(OUT_W),
      .TAG_W(TAG_W)
   ) u_mag (
      .clk(MCLK),
      .rst(reset),
      .v_i(wr_v),
      .re_i(source_real),
      .im_i(source_imag),
      .tag_i({exp_q, wr_last, nb_q, wr_idx}),
      .v_o(p_v),
      .mag_o(p_mag),
      .tag_o(p_tag)
   );
   // last pipe stage writes into the bank chosen when the beat was accepted
   always_ff @(posedge MCLK) begin
      if (p_v) ram[{p_bank, p_idx}] <= p_mag;
   end
   // read side always sees the bank not being written
   always_ff @(posedge MCLK) begin
      rd_q <= reset ? '0 : ram[{~wr_bank_q, rd_addr}];
   end
   // commit swaps banks and publishes the frame's exponent and count
   always_ff @(posedge MCLK) begin
      if (reset) begin
         wr_bank_q <= 1'b0;
         count_q <= '0;
         fexp_q <= '0;
      end else if (frame_done) begin
         wr_bank_q <= ~wr_bank_q;
         count_q <= count_q + 8'd1;
         fexp_q <= p_exp;
      end
   end
endmodule
